// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    function automatic logic is_signed(input md_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div(input md_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_arith(input md_op_t op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude engine: shift-add for multiply, restoring
// shift-subtract for divide. acc holds {upper half, lower half}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial_rem;
    logic [WIDTH-1:0] diff;

    // Remainder is always below the divisor, so the W-bit difference is exact.
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
        trial_rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff      = trial_rem[WIDTH-1:0] - divisor;
        acc_next  = {sum, acc[WIDTH-1:1]};
        if (div) begin
            if (trial_rem >= {1'b0, divisor}) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {trial_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers, with busy/done handshake.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_t          state, state_next;
    logic [2*WIDTH-1:0] acc, acc_step, acc_init, prod_fix;
    logic [WIDTH-1:0]   mag_b, abs_a, abs_b, hi_fix, lo_fix;
    logic [CNT_W-1:0]   cnt;
    logic               div_op, neg_res, neg_rem;
    logic               sgn, a_neg, b_neg, b_zero, neg_res_init, neg_rem_init, skip_calc;
    logic               issue_md, issue_mt, finish;

    // Operand conditioning at issue. A zero divisor keeps the raw dividend so
    // the remainder half comes out as `a` and no sign fix is applied.
    always_comb begin
        sgn          = is_signed(op);
        a_neg        = sgn && a[WIDTH-1];
        b_neg        = sgn && b[WIDTH-1];
        b_zero       = is_div(op) && (b == '0);
        abs_a        = (a_neg && !b_zero) ? -a : a;
        abs_b        = b_neg ? -b : b;
        neg_res_init = (a_neg ^ b_neg) && !b_zero;
        neg_rem_init = a_neg && is_div(op) && !b_zero;
        acc_init     = {{WIDTH{1'b0}}, abs_a};
        skip_calc    = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div(op)) begin
            acc_init     = {{WIDTH{a_neg}}, a} * {{WIDTH{b_neg}}, b};
            skip_calc    = 1'b1;
            neg_res_init = 1'b0;
        end
`else
`endif
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div      (div_op),
        .acc      (acc),
        .divisor  (mag_b),
        .acc_next (acc_step)
    );

    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
        if (div_op) begin
            lo_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi_fix = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // abort outranks start in IDLE and cancels CALC/FIX without touching HI/LO.
    always_comb begin
        state_next = state;
        issue_md   = 1'b0;
        issue_mt   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (is_arith(op)) begin
                        issue_md   = 1'b1;
                        state_next = skip_calc ? FIX : CALC;
                    end else if (op == MTHI || op == MTLO) begin
                        issue_mt   = 1'b1;
                    end
                end
            end
            CALC: begin
                if (abort)                           state_next = IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))   state_next = FIX;
            end
            FIX: begin
                state_next = IDLE;
                finish     = !abort;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            mag_b   <= '0;
            cnt     <= '0;
            div_op  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= finish;
            if (issue_md) begin
                acc     <= acc_init;
                mag_b   <= abs_b;
                cnt     <= '0;
                div_op  <= is_div(op);
                neg_res <= neg_res_init;
                neg_rem <= neg_rem_init;
            end else if (state == CALC && !abort) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end
            if (issue_mt) begin
                if (op == MTHI) hi <= a;
                else            lo <= a;
            end
            if (finish) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit (WIDTH=32), honouring MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    md_op_t      op;
    logic [31:0] a, b;
    logic        abort;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} built from plain wide arithmetic.
    function automatic logic [63:0] model(input md_op_t mop, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        logic [63:0] ux = {32'b0, x};
        logic [63:0] uy = {32'b0, y};
        logic [63:0] q, r;
        case (mop)
            MULT:  return 64'(sx * sy);
            MULTU: return ux * uy;
            DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = 64'(sx / sy);
                r = 64'(sx % sy);
                return {r[31:0], q[31:0]};
            end
            DIVU: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = ux / uy;
                r = ux % uy;
                return {r[31:0], q[31:0]};
            end
            default: return 64'b0;
        endcase
    endfunction

    function automatic int latency(input md_op_t mop);
`ifdef MULDIV_FAST_MUL_EN
        return is_div(mop) ? 34 : 2;
`else
        return 34;
`endif
    endfunction

    // Issue at the current cycle (cycle 0) and wait for done, checking timing and result.
    task automatic run_op(input string tag, input md_op_t mop, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
        int cyc;
        logic busy_ok;
        logic [63:0] want;
        start = 1'b1; op = mop; a = x; b = y;
        sb_q.push_back(exp);
        tick();
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        want = sb_q.pop_front();
        check({tag, "_lat"}, 32'(cyc), 32'(latency(mop)));
        check({tag, "_busy_run"}, {31'b0, busy_ok}, 32'd1);
        check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        check({tag, "_hi"}, hi, want[63:32]);
        check({tag, "_lo"}, lo, want[31:0]);
    endtask

    initial begin
        int cyc;
        logic saw_done;
        logic [31:0] rx, ry;
        reset = 1'b0; start = 1'b0; op = MULTU; a = '0; b = '0; abort = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        check("done_pulse_prev", {31'b0, done}, 32'd1);
        run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu", DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("div_zero", DIV, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
        run_op("div_neg_zero", DIV, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF);

        for (int i = 0; i < 4; i++) begin
            md_op_t rop;
            rop = md_op_t'(i);
            rx = $urandom;
            ry = (i == 3) ? ($urandom & 32'h0000_FFFF) : $urandom;
            run_op($sformatf("rand%0d", i), rop, rx, ry, model(rop, rx, ry));
        end
        tick();
        check("done_cleared", {31'b0, done}, 32'd0);

        // MTHI/MTLO: value visible one cycle later without busy or done.
        start = 1'b1; op = MTHI; a = 32'd5;
        tick();
        start = 1'b0;
        check("mthi_val", hi, 32'd5);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        check("mthi_done", {31'b0, done}, 32'd0);
        start = 1'b1; op = MTLO; a = 32'd6;
        tick();
        start = 1'b0;
        check("mtlo_val", lo, 32'd6);

        start = 1'b1; abort = 1'b1; op = MTHI; a = 32'd99;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_wins_hi", hi, 32'd5);

        // DIVU aborted in cycle 10, with an ignored start in cycle 5.
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c == 5) begin start = 1'b1; op = MULTU; a = 32'd9; b = 32'd9; end
            else        start = 1'b0;
            tick();
        end
        start = 1'b0;
        check("abort_busy_c10", {31'b0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy_c11", {31'b0, busy}, 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) saw_done = 1'b1;
            tick();
        end
        check("abort_quiet", {31'b0, saw_done}, 32'd0);
        check("abort_hi", hi, 32'd5);
        check("abort_lo", lo, 32'd6);

        // Reset mid-CALC clears everything immediately.
        start = 1'b1; op = MULTU; a = 32'd11; b = 32'd13;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        run_op("post_rst_multu", MULTU, 32'd3, 32'd4, 64'd12);

        cyc = sb_q.size();
        check("sb_empty", 32'(cyc), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
